multi_channel_sink: RTL and testbench

- Parametrised successor of the single-channel NoC sink.
- Terminates CHANNELS independent two-phase (transition-signalled) req/ack links.
- Buffers each link in its own FIFO, applies back-pressure by withholding ack when that FIFO is full, and drains all FIFOs through one round-robin output port.
- Keeps per-channel packet counts and sticky misroute flags; instantiated at router exit ports and in testbenches as a traffic endpoint.

---
 rtl/multi_channel_sink_pkg.sv | 16 +
 rtl/multi_channel_sink_fifo.sv | 51 +++++
 rtl/multi_channel_sink.sv | 139 +++++++++++++
 tb/tb_multi_channel_sink.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_sink_pkg.sv
// Shared helpers for the multi-channel sink: index-width arithmetic used by ports and FIFOs.
package multi_channel_sink_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_sink_fifo.sv
// Per-channel packet FIFO; wrap-bit pointers give full/empty by comparison.
module sink_fifo
    import multi_channel_sink_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [SIZE-1:0] wr_data,
    input  logic            rd_en,
    output logic [SIZE-1:0] rd_data,
    output logic            full,
    output logic            empty
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SIZE-1:0] mem_q [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full)  wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (wr_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/multi_channel_sink.sv
// NoC traffic endpoint: terminates CHANNELS two-phase req/ack links into per-channel FIFOs
// and drains them round-robin through one registered output port.
module multi_channel_sink
    import multi_channel_sink_pkg::*;
#(
    parameter int unsigned ID               = 0,
    parameter int unsigned SIZE             = 8,
    parameter int unsigned DESTINATION_BITS = 4,
    parameter int unsigned PORT_BITS        = 4,
    parameter int unsigned CHANNELS         = 4,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned COUNT_BITS       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            req,
    output logic [CHANNELS-1:0]            ack,
    input  logic [CHANNELS*SIZE-1:0]       data,
    input  logic                           drain_en,
    output logic                           out_valid,
    output logic [idx_bits(CHANNELS)-1:0]  out_channel,
    output logic [SIZE-1:0]                out_data,
    output logic [CHANNELS*COUNT_BITS-1:0] rx_count,
    output logic [CHANNELS-1:0]            misroute
);
    localparam int unsigned CW = idx_bits(CHANNELS);

    logic [CHANNELS-1:0]   req_old_q, req_old_d;
    logic [CHANNELS-1:0]   ack_q, ack_d;
    logic [CHANNELS-1:0]   mis_q, mis_d;
    logic [COUNT_BITS-1:0] cnt_q [CHANNELS];
    logic [COUNT_BITS-1:0] cnt_d [CHANNELS];
    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_channel_q, out_channel_d;
    logic [SIZE-1:0]       out_data_q, out_data_d;
    logic [CW-1:0]         rr_q, rr_d;

    logic [CHANNELS-1:0]   accept_c;
    logic [CHANNELS-1:0]   pop_c;
    logic [CHANNELS-1:0]   full_c;
    logic [CHANNELS-1:0]   empty_c;
    logic [SIZE-1:0]       rd_data_c [CHANNELS];
    logic                  found_c;
    logic [CW-1:0]         sel_c;
    logic [31:0]           scan_idx;

    logic unused_port_bits;
    assign unused_port_bits = ^32'(PORT_BITS);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sink_fifo #(
            .SIZE  (SIZE),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (accept_c[c]),
            .wr_data (data[c*SIZE +: SIZE]),
            .rd_en   (pop_c[c]),
            .rd_data (rd_data_c[c]),
            .full    (full_c[c]),
            .empty   (empty_c[c])
        );
        assign rx_count[c*COUNT_BITS +: COUNT_BITS] = cnt_q[c];
    end

    assign ack         = ack_q;
    assign misroute    = mis_q;
    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign out_data    = out_data_q;

    // Handshake: a req/req_old mismatch is a pending packet, taken only when its FIFO has room.
    always_comb begin
        req_old_d = req_old_q;
        ack_d     = ack_q;
        mis_d     = mis_q;
        cnt_d     = cnt_q;
        accept_c  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            accept_c[c] = (req[c] != req_old_q[c]) && !full_c[c];
            if (accept_c[c]) begin
                req_old_d[c] = req[c];
                ack_d[c]     = ~ack_q[c];
                if (cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + COUNT_BITS'(1);
                if (data[c*SIZE +: DESTINATION_BITS] != DESTINATION_BITS'(ID)) mis_d[c] = 1'b1;
            end
        end
    end

    // Round-robin drain: first non-empty FIFO at or after the pointer, with wrap-around.
    always_comb begin
        found_c       = 1'b0;
        sel_c         = '0;
        scan_idx      = '0;
        pop_c         = '0;
        out_valid_d   = 1'b0;
        out_channel_d = out_channel_q;
        out_data_d    = out_data_q;
        rr_d          = rr_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            scan_idx = (32'(rr_q) + 32'(i)) % 32'(CHANNELS);
            if (!found_c && !empty_c[CW'(scan_idx)]) begin
                found_c = 1'b1;
                sel_c   = CW'(scan_idx);
            end
        end
        if (drain_en && found_c) begin
            pop_c[sel_c]  = 1'b1;
            out_valid_d   = 1'b1;
            out_channel_d = sel_c;
            out_data_d    = rd_data_c[sel_c];
            rr_d          = (sel_c == CW'(CHANNELS - 1)) ? '0 : sel_c + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_old_q     <= '0;
            ack_q         <= '0;
            mis_q         <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            rr_q          <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
        end else begin
            req_old_q     <= req_old_d;
            ack_q         <= ack_d;
            mis_q         <= mis_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multi_channel_sink.sv
// Bench for multi_channel_sink: directed table, corner sequences, then random traffic vs a queue model.
module tb_multi_channel_sink;
    localparam int unsigned ID    = 3;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  ack;
    logic [31:0] data = '0;
    logic        drain_en = 1'b0;
    logic        out_valid;
    logic [1:0]  out_channel;
    logic [7:0]  out_data;
    logic [63:0] rx_count;
    logic [3:0]  misroute;

    int n_pass = 0;
    int n_total = 0;

    multi_channel_sink #(
        .ID(ID), .SIZE(8), .DESTINATION_BITS(4), .PORT_BITS(4),
        .CHANNELS(NCH), .DEPTH(DEPTH), .COUNT_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .data(data),
        .drain_en(drain_en), .out_valid(out_valid), .out_channel(out_channel),
        .out_data(out_data), .rx_count(rx_count), .misroute(misroute)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus per-channel bookkeeping.
    logic [7:0] mq [4][$];
    logic [3:0] m_ack = '0, m_req_old = '0, m_mis = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};
    int         m_rr = 0;
    logic       m_ov = 1'b0;
    logic [1:0] m_och = '0;
    logic [7:0] m_od = '0;

    task automatic model_step();
        logic [3:0] acc;
        bit found;
        int start, c;
        for (int i = 0; i < 4; i++)
            acc[i] = (req[i] != m_req_old[i]) && (mq[i].size() < DEPTH);
        m_ov = 1'b0;
        found = 0;
        start = m_rr;
        if (drain_en) begin
            for (int i = 0; i < 4; i++) begin
                c = (start + i) % 4;
                if (!found && mq[c].size() > 0) begin
                    found = 1;
                    m_od = mq[c].pop_front();
                    m_och = 2'(c);
                    m_ov = 1'b1;
                    m_rr = (c + 1) % 4;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                mq[i].push_back(data[i*8 +: 8]);
                m_req_old[i] = req[i];
                m_ack[i] = ~m_ack[i];
                if (m_cnt[i] < 65535) m_cnt[i]++;
                if (data[i*8 +: 4] != 4'(ID)) m_mis[i] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_cnt[i] = 0;
            end
            m_ack = '0; m_req_old = '0; m_mis = '0; m_rr = 0;
            m_ov = 1'b0; m_och = '0; m_od = '0;
        end else begin
            model_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("mdl_ack", 64'(ack), 64'(m_ack));
        check("mdl_out_valid", 64'(out_valid), 64'(m_ov));
        check("mdl_out_channel", 64'(out_channel), 64'(m_och));
        check("mdl_out_data", 64'(out_data), 64'(m_od));
        check("mdl_rx_count", rx_count,
              {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
        check("mdl_misroute", 64'(misroute), 64'(m_mis));
    endtask

    // One clock; returns at the following negedge with outputs settled and model-checked.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        int          ch;
        logic [7:0]  d;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_mis;
        logic [63:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int got;
        int pct;
        vecs[0] = '{0, 8'h53, 4'b0001, 4'b0000, 64'h0000_0000_0000_0001};
        vecs[1] = '{2, 8'h57, 4'b0101, 4'b0100, 64'h0000_0001_0000_0001};
        vecs[2] = '{2, 8'h13, 4'b0001, 4'b0100, 64'h0000_0002_0000_0001};
        vecs[3] = '{1, 8'hA3, 4'b0011, 4'b0100, 64'h0000_0002_0001_0001};
        vecs[4] = '{3, 8'hF0, 4'b1011, 4'b1100, 64'h0001_0002_0001_0001};

        repeat (3) cyc();
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_channel", 64'(out_channel), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_rx_count", rx_count, 64'h0);
        check("rst_misroute", 64'(misroute), 64'h0);
        reset = 1'b1;
        cyc();

        // Single packets, drain enabled: ack next cycle, output one cycle later.
        drain_en = 1'b1;
        foreach (vecs[i]) begin
            data[vecs[i].ch*8 +: 8] = vecs[i].d;
            req[vecs[i].ch] = ~req[vecs[i].ch];
            cyc();
            check("vec_ack", 64'(ack), 64'(vecs[i].exp_ack));
            check("vec_misroute", 64'(misroute), 64'(vecs[i].exp_mis));
            check("vec_rx_count", rx_count, vecs[i].exp_rx);
            cyc();
            check("vec_out_valid", 64'(out_valid), 64'h1);
            check("vec_out_channel", 64'(out_channel), 64'(vecs[i].ch));
            check("vec_out_data", 64'(out_data), 64'(vecs[i].d));
        end
        cyc();
        check("idle_out_valid", 64'(out_valid), 64'h0);

        // Back-pressure on channel 1: fifth packet waits for a pop.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data[15:8] = 8'(16 * (i + 1) + 3);
            req[1] = ~req[1];
            cyc();
            check("bp_ack", 64'(ack[1]), 64'((i % 2 == 0) ? 0 : 1));
        end
        data[15:8] = 8'h53;
        req[1] = ~req[1];
        repeat (3) begin
            cyc();
            check("bp_withheld", 64'(ack[1]), 64'h1);
        end
        drain_en = 1'b1;
        cyc();
        check("bp_pop1_valid", 64'(out_valid), 64'h1);
        check("bp_pop1_data", 64'(out_data), 64'h13);
        check("bp_still_withheld", 64'(ack[1]), 64'h1);
        cyc();
        check("bp_late_ack", 64'(ack[1]), 64'h0);
        check("bp_pop2_data", 64'(out_data), 64'h23);
        got = 2;
        for (int t = 0; t < 10 && got < 5; t++) begin
            cyc();
            if (out_valid) begin
                check("bp_order", 64'(out_data), 64'(16 * (got + 1) + 3));
                got++;
            end
        end
        check("bp_drained", 64'(got), 64'd5);

        // Asynchronous reset between edges with FIFOs half full.
        drain_en = 1'b0;
        data[7:0] = 8'h63; data[15:8] = 8'h73;
        req[0] = ~req[0]; req[1] = ~req[1];
        cyc();
        data[7:0] = 8'h83; data[15:8] = 8'h93;
        req[0] = ~req[0]; req[1] = ~req[1];
        cyc();
        #2;
        reset = 1'b0;
        req = '0;
        #1;
        check("arst_ack", 64'(ack), 64'h0);
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_channel", 64'(out_channel), 64'h0);
        check("arst_out_data", 64'(out_data), 64'h0);
        check("arst_rx_count", rx_count, 64'h0);
        check("arst_misroute", 64'(misroute), 64'h0);
        @(negedge clk);
        cyc();
        reset = 1'b1;
        cyc();

        // Simultaneous arrival on all channels, twice, then round-robin drain.
        for (int c = 0; c < 4; c++) data[c*8 +: 8] = 8'(c * 16 + 3);
        req = ~req;
        cyc();
        check("sim_ack", 64'(ack), 64'hF);
        check("sim_rx_restart", rx_count, 64'h0001_0001_0001_0001);
        for (int c = 0; c < 4; c++) data[c*8 +: 8] = 8'(c * 16 + 8'h43);
        req = ~req;
        cyc();
        check("sim_ack2", 64'(ack), 64'h0);
        drain_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("rr_valid", 64'(out_valid), 64'h1);
            check("rr_channel", 64'(out_channel), 64'(k % 4));
            check("rr_data", 64'(out_data), 64'(k * 16 + 3));
        end
        cyc();
        check("rr_idle", 64'(out_valid), 64'h0);

        // Random traffic with alternating light/heavy drain to exercise full FIFOs.
        for (int t = 0; t < 3000; t++) begin
            pct = ((t / 200) % 2 == 1) ? 80 : 15;
            drain_en = ($urandom_range(0, 99) < pct);
            for (int c = 0; c < 4; c++) begin
                if (req[c] == m_ack[c] && $urandom_range(0, 1) == 1) begin
                    data[c*8 +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(ID);
                    data[c*8 + 4 +: 4] = 4'($urandom);
                    req[c] = ~req[c];
                end
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
